// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq
//   Wishbone-master transfer sequencer for the spi core. It takes one
//   transfer request per valid/ready handshake and programs the core:
//   DIVIDE, SS, TX_0, then CTRL with GO set. It then waits for the core
//   interrupt, reads RX_0 and returns that word on a response handshake.
//   DIVIDE and SS writes are skipped when the cached value matches.
//
// Handshakes (valid/ready): a transfer happens on a rising wb_clk_i edge
//   where valid and ready are both 1. A producer holds valid and its
//   payload stable until that edge. Here req_ready is 1 only in IDLE.
//   rsp_valid, rsp_data and rsp_err stay stable until rsp_ready is seen.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   req_valid/req_ready       request handshake
//   req_data/len/ss/div/mode  request payload (len 0 means 32 bits;
//                             mode = {lsb, tx_negedge, rx_negedge})
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_err         RX word; 00 ok, 01 bus error, 10 timeout
//   m_*                       Wishbone master port to the core
//   spi_int_i                 core interrupt
//   dbg_state                 current FSM state (state_t encoding)

module spi_xfer_seq #(
  parameter int TIMEOUT_W = 20,
  parameter int SS_W      = 8,
  parameter int DIV_W     = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_data,
  input  logic [5:0]       req_len,
  input  logic [SS_W-1:0]  req_ss,
  input  logic [DIV_W-1:0] req_div,
  input  logic [2:0]       req_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [1:0]       rsp_err,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [4:0]       m_adr_o,
  output logic [31:0]      m_dat_o,
  output logic [3:0]       m_sel_o,
  input  logic [31:0]      m_dat_i,
  input  logic             m_ack_i,
  input  logic             m_err_i,
  input  logic             spi_int_i,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_DIV   = 3'd1,
    WR_SS    = 3'd2,
    WR_TX    = 3'd3,
    WR_CTRL  = 3'd4,
    WAIT_INT = 3'd5,
    RD_RX    = 3'd6,
    RESP     = 3'd7
  } state_t;

  localparam logic [4:0] ADR_TXRX = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;

  // Watchdog fires on the cycle the count would reach 2^TIMEOUT_W-1.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);

  state_t               state_q, state_d;
  logic [31:0]          data_q;
  logic [5:0]           len_q;
  logic [SS_W-1:0]      ss_q;
  logic [DIV_W-1:0]     div_q;
  logic [2:0]           mode_q;
  logic [DIV_W-1:0]     div_cache;
  logic [SS_W-1:0]      ss_cache;
  logic                 div_cache_vld, ss_cache_vld;
  logic [TIMEOUT_W-1:0] wd_q;

  logic        launch, bus_ok, bus_fail, wd_fire;
  logic        div_hit_in, ss_hit_in, ss_hit_q;
  logic        bus_we;
  logic [4:0]  bus_adr;
  logic [31:0] bus_dat;
  logic [31:0] ctrl_word;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign m_sel_o   = m_cyc_o ? 4'hF : 4'h0;
  assign dbg_state = state_q;

  assign bus_ok   = m_cyc_o & m_ack_i & ~m_err_i;
  assign bus_fail = m_cyc_o & m_err_i;
  // Interrupt has priority over the watchdog.
  assign wd_fire  = (state_q == WAIT_INT) & ~spi_int_i & (wd_q == WD_LAST);

  // Skip decisions: on accept compare against the incoming request, later
  // against the latched copy.
  assign div_hit_in = div_cache_vld & (div_cache == req_div);
  assign ss_hit_in  = ss_cache_vld & (ss_cache == req_ss);
  assign ss_hit_q   = ss_cache_vld & (ss_cache == ss_q);

  always_comb begin
    ctrl_word       = '0;
    ctrl_word[6:0]  = (len_q == 6'd0) ? 7'd32 : {1'b0, len_q};
    ctrl_word[8]    = 1'b1;       // GO
    ctrl_word[9]    = mode_q[0];  // RX_NEGEDGE
    ctrl_word[10]   = mode_q[1];  // TX_NEGEDGE
    ctrl_word[11]   = mode_q[2];  // LSB
    ctrl_word[12]   = 1'b1;       // IE
    ctrl_word[13]   = 1'b1;       // ASS
  end

  always_comb begin
    bus_we  = 1'b1;
    bus_adr = ADR_TXRX;
    bus_dat = '0;
    case (state_q)
      WR_DIV:  begin bus_adr = ADR_DIV;  bus_dat = 32'(div_q); end
      WR_SS:   begin bus_adr = ADR_SS;   bus_dat = 32'(ss_q);  end
      WR_TX:   begin bus_adr = ADR_TXRX; bus_dat = data_q;     end
      WR_CTRL: begin bus_adr = ADR_CTRL; bus_dat = ctrl_word;  end
      RD_RX:   begin bus_adr = ADR_TXRX; bus_we = 1'b0;        end
      default: ;
    endcase
  end

  // Next state. Access states launch a cycle whenever the bus is idle; the
  // cycle after an ack/err always has cyc low, which gives the gap between
  // back-to-back accesses.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!div_hit_in)     state_d = WR_DIV;
          else if (!ss_hit_in) state_d = WR_SS;
          else                 state_d = WR_TX;
        end
      end
      WR_DIV, WR_SS, WR_TX, WR_CTRL, RD_RX: begin
        if (!m_cyc_o) begin
          launch = 1'b1;
        end else if (bus_fail) begin
          state_d = RESP;
        end else if (bus_ok) begin
          case (state_q)
            WR_DIV:  state_d = ss_hit_q ? WR_TX : WR_SS;
            WR_SS:   state_d = WR_TX;
            WR_TX:   state_d = WR_CTRL;
            WR_CTRL: state_d = WAIT_INT;
            default: state_d = RESP;
          endcase
        end
      end
      WAIT_INT: begin
        if (spi_int_i)    state_d = RD_RX;
        else if (wd_fire) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      data_q        <= '0;
      len_q         <= '0;
      ss_q          <= '0;
      div_q         <= '0;
      mode_q        <= '0;
      div_cache     <= '0;
      ss_cache      <= '0;
      div_cache_vld <= 1'b0;
      ss_cache_vld  <= 1'b0;
      wd_q          <= '0;
      rsp_data      <= '0;
      rsp_err       <= 2'b00;
      m_cyc_o       <= 1'b0;
      m_stb_o       <= 1'b0;
      m_we_o        <= 1'b0;
      m_adr_o       <= '0;
      m_dat_o       <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && req_valid) begin
        data_q <= req_data;
        len_q  <= req_len;
        ss_q   <= req_ss;
        div_q  <= req_div;
        mode_q <= req_mode;
      end

      if (launch) begin
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        m_we_o  <= bus_we;
        m_adr_o <= bus_adr;
        m_dat_o <= bus_dat;
      end else if (m_cyc_o && (m_ack_i || m_err_i)) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
        m_we_o  <= 1'b0;
        m_adr_o <= '0;
        m_dat_o <= '0;
      end

      if (bus_ok) begin
        case (state_q)
          WR_DIV: begin div_cache <= div_q; div_cache_vld <= 1'b1; end
          WR_SS:  begin ss_cache  <= ss_q;  ss_cache_vld  <= 1'b1; end
          RD_RX:  begin rsp_data  <= m_dat_i; rsp_err <= 2'b00; end
          default: ;
        endcase
      end

      // A failed access or a dead core leaves the core's register contents
      // unknown, so neither cache can be trusted afterwards.
      if (bus_fail || wd_fire) begin
        div_cache_vld <= 1'b0;
        ss_cache_vld  <= 1'b0;
        rsp_data      <= '0;
        rsp_err       <= bus_fail ? 2'b01 : 2'b10;
      end

      if (state_q == WAIT_INT) wd_q <= wd_q + TIMEOUT_W'(1);
      else                     wd_q <= '0;
    end
  end

endmodule
